// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: states and constants shared by uart_bus_ctrl and its access sequencer.
// UART_CTRL_ERRCLR_EN adds the S_ERRCLR state.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        S_URST,
        S_MODE,
        S_CMD,
        S_IDLE,
        S_TX,
        S_RX,
`ifdef UART_CTRL_ERRCLR_EN
        S_ERRCLR,
`endif
        S_RECOV
    } uart_ctrl_state_t;

    localparam logic [7:0] CMD_ER_BIT   = 8'h10;
    localparam int         RECOV_CYCLES = 2;

endpackage

// File: rtl/uart_bus_access.sv
// uart_bus_access: one setup / STROBE_CYCLES strobe-low / one hold bus access to the UART.
module uart_bus_access #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       n_RST,
    input  logic       start,
    input  logic       rnw,
    input  logic       c_nd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    input  logic [7:0] u_DATA_OUT,
    output logic       u_n_CS,
    output logic       u_C_nD,
    output logic       u_n_RD,
    output logic       u_n_WR,
    output logic [7:0] u_DATA_IN
);
    // phase 0 idle, 1 setup, 2..HOLD-1 strobe low, HOLD hold
    localparam logic [7:0] HOLD = 8'(STROBE_CYCLES + 2);

    logic [7:0] ph_q, ph_d, data_q, data_d, rdata_q, rdata_d;
    logic       rnw_q, rnw_d, cnd_q, cnd_d, load, strobe;

    assign busy      = ph_q != 8'd0;
    assign done      = ph_q == HOLD;
    assign load      = start && !busy;
    assign strobe    = ph_q > 8'd1 && ph_q < HOLD;
    assign u_n_CS    = !busy;
    assign u_n_RD    = !(strobe && rnw_q);
    assign u_n_WR    = !(strobe && !rnw_q);
    assign u_C_nD    = cnd_q;
    assign u_DATA_IN = data_q;
    assign rdata     = rdata_q;

    always_comb begin
        ph_d    = done ? 8'd0 : (busy || start) ? ph_q + 8'd1 : 8'd0;
        rnw_d   = load ? rnw : rnw_q;
        cnd_d   = load ? c_nd : cnd_q;
        data_d  = load ? wdata : data_q;
        rdata_d = (rnw_q && ph_q == HOLD - 8'd1) ? u_DATA_OUT : rdata_q;
    end

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            ph_q    <= 8'd0;
            rnw_q   <= 1'b0;
            cnd_q   <= 1'b0;
            data_q  <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            ph_q    <= ph_d;
            rnw_q   <= rnw_d;
            cnd_q   <= cnd_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: initialises the 8251-style UART and arbitrates TX writes / RX reads on its bus.
// UART_CTRL_ERRCLR_EN: a read with PE/FE set is followed by an error-reset command write.
module uart_bus_ctrl import uart_ctrl_pkg::*; #(
    parameter logic [7:0] MODE_WORD     = 8'h4E,
    parameter logic [7:0] CMD_WORD      = 8'h15,
    parameter int         STROBE_CYCLES = 2,
    parameter int         RST_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       n_RST,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [1:0] rx_err,
    output logic       init_done,
    output logic       u_n_RST,
    output logic       u_n_CS,
    output logic       u_C_nD,
    output logic       u_n_RD,
    output logic       u_n_WR,
    output logic [7:0] u_DATA_IN,
    input  logic [7:0] u_DATA_OUT,
    input  logic       u_Rx_RDY,
    input  logic       u_Tx_RDY,
    input  logic       u_PE_Fg,
    input  logic       u_FE_Fg
);
    uart_ctrl_state_t state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             last_tx_q, last_tx_d, init_q, init_d;
    logic             start, rnw, c_nd, busy, done, grant_rx, grant_tx;
    logic [7:0]       wdata;

    uart_bus_access #(.STROBE_CYCLES(STROBE_CYCLES)) u_access (
        .clk        (clk),
        .n_RST      (n_RST),
        .start      (start),
        .rnw        (rnw),
        .c_nd       (c_nd),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rx_data),
        .u_DATA_OUT (u_DATA_OUT),
        .u_n_CS     (u_n_CS),
        .u_C_nD     (u_C_nD),
        .u_n_RD     (u_n_RD),
        .u_n_WR     (u_n_WR),
        .u_DATA_IN  (u_DATA_IN)
    );

    // round-robin: RX wins a tie unless it was the last side served
    assign grant_rx  = state_q == S_IDLE && u_Rx_RDY && !(tx_valid && u_Tx_RDY && !last_tx_q);
    assign grant_tx  = state_q == S_IDLE && tx_valid && u_Tx_RDY && !grant_rx;
    assign tx_ready  = grant_tx;
    assign rx_valid  = state_q == S_RX && done;
    assign rx_err    = err_q;
    assign init_done = init_q;
    assign u_n_RST   = !(state_q == S_URST && cnt_q < 16'(RST_CYCLES));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        last_tx_d = last_tx_q;
        start     = 1'b0;
        rnw       = 1'b0;
        c_nd      = 1'b0;
        wdata     = tx_data;
        case (state_q)
            S_URST: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(RST_CYCLES)) begin
                    state_d = S_MODE;
                    cnt_d   = 16'd0;
                end
            end
            S_MODE, S_CMD: begin
                c_nd  = 1'b1;
                wdata = (state_q == S_MODE) ? MODE_WORD : CMD_WORD;
                start = cnt_q == 16'd0;
                cnt_d = 16'd1;
                if (cnt_q != 16'd0 && !busy) begin
                    state_d = (state_q == S_MODE) ? S_CMD : S_IDLE;
                    cnt_d   = 16'd0;
                end
            end
            S_IDLE: begin
                start     = grant_rx || grant_tx;
                rnw       = grant_rx;
                state_d   = grant_rx ? S_RX : grant_tx ? S_TX : S_IDLE;
                last_tx_d = grant_tx || (last_tx_q && !grant_rx);
                cnt_d     = 16'd0;
            end
            S_TX: state_d = done ? S_RECOV : S_TX;
            S_RX: begin
                cnt_d = cnt_q + 16'd1;
                err_d = (cnt_q == 16'(STROBE_CYCLES)) ? {u_FE_Fg, u_PE_Fg} : err_q;
                if (done) begin
                    cnt_d = 16'd0;
`ifdef UART_CTRL_ERRCLR_EN
                    state_d = (err_q != 2'b00) ? S_ERRCLR : S_RECOV;
`else
                    state_d = S_RECOV;
`endif
                end
            end
`ifdef UART_CTRL_ERRCLR_EN
            S_ERRCLR: begin
                c_nd  = 1'b1;
                wdata = CMD_WORD | CMD_ER_BIT;
                start = cnt_q == 16'd0;
                cnt_d = 16'd1;
                if (cnt_q != 16'd0 && !busy) begin
                    state_d = S_RECOV;
                    cnt_d   = 16'd0;
                end
            end
`endif
            S_RECOV: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(RECOV_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: state_d = S_URST;
        endcase
        init_d = init_q || state_d == S_IDLE;
    end

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            state_q   <= S_URST;
            cnt_q     <= 16'd0;
            err_q     <= 2'b00;
            last_tx_q <= 1'b1;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            last_tx_q <= last_tx_d;
            init_q    <= init_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: scoreboard bench for uart_bus_ctrl; bus accesses and received bytes
// are queued when stimulus is applied and checked when the DUT produces them.
module tb_uart_bus_ctrl;

    typedef struct packed {
        logic       rd;
        logic       cnd;
        logic [7:0] d;
    } acc_t;

    logic       clk, n_RST, tx_valid, tx_ready, rx_valid, init_done;
    logic [7:0] tx_data, rx_data, u_DATA_IN, u_DATA_OUT;
    logic [1:0] rx_err;
    logic       u_n_RST, u_n_CS, u_C_nD, u_n_RD, u_n_WR, u_Rx_RDY, u_Tx_RDY, u_PE_Fg, u_FE_Fg;

    int         vectors = 0;
    int         miscompares = 0;
    acc_t       acc_q[$];
    logic [9:0] rx_q[$];

    uart_bus_ctrl dut (
        .clk        (clk),
        .n_RST      (n_RST),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .init_done  (init_done),
        .u_n_RST    (u_n_RST),
        .u_n_CS     (u_n_CS),
        .u_C_nD     (u_C_nD),
        .u_n_RD     (u_n_RD),
        .u_n_WR     (u_n_WR),
        .u_DATA_IN  (u_DATA_IN),
        .u_DATA_OUT (u_DATA_OUT),
        .u_Rx_RDY   (u_Rx_RDY),
        .u_Tx_RDY   (u_Tx_RDY),
        .u_PE_Fg    (u_PE_Fg),
        .u_FE_Fg    (u_FE_Fg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic cnd, input logic [7:0] d);
        acc_q.push_back({1'b0, cnd, d});
    endtask

    task automatic push_r();
        acc_q.push_back({1'b1, 1'b0, 8'h00});
    endtask

    // releases reset and times the start-up sequence
    task automatic do_init();
        int rst_hi = 0;
        int done_at = 0;
        push_w(1'b1, 8'h4E);
        push_w(1'b1, 8'h15);
        @(negedge clk);
        n_RST = 1'b1;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            if (u_n_RST && rst_hi == 0) rst_hi = k;
            if (init_done) done_at = k;
        end
        chk("urst_len", 32'(rst_hi), 32'd8);
        chk("init_at", 32'(done_at), 32'd21);
        chk("init_writes_left", 32'(acc_q.size()), 32'd0);
    endtask

    // bus and receive-stream monitor
    initial begin
        logic pwr = 1'b1;
        logic prd = 1'b1;
        int   wl = 0;
        int   rl = 0;
        acc_t a;
        forever begin
            @(negedge clk);
            if (!n_RST) begin
                wl = 0;
                rl = 0;
            end else begin
                if (!u_n_WR || !u_n_RD) begin
                    if ((!u_n_WR && pwr) || (!u_n_RD && prd)) begin
                        vectors++;
                        assert (acc_q.size() != 0) else begin
                            miscompares++;
                            $error("FAIL unexpected_access: observed rd=%0b data=%0h expected none", !u_n_RD, u_DATA_IN);
                        end
                        if (acc_q.size() != 0) begin
                            a = acc_q.pop_front();
                            chk("access", !u_n_RD ? 32'({1'b1, u_C_nD, 8'h00}) : 32'({1'b0, u_C_nD, u_DATA_IN}), 32'(a));
                        end
                        chk("cs_low", 32'(u_n_CS), 32'd0);
                    end
                end
                if (!u_n_WR) wl++;
                else if (!pwr) begin
                    chk("wr_width", 32'(wl), 32'd2);
                    wl = 0;
                end
                if (!u_n_RD) rl++;
                else if (!prd) begin
                    chk("rd_width", 32'(rl), 32'd2);
                    rl = 0;
                end
                if (rx_valid) begin
                    vectors++;
                    assert (rx_q.size() != 0) else begin
                        miscompares++;
                        $error("FAIL unexpected_rx: observed %0h expected none", {rx_err, rx_data});
                    end
                    if (rx_q.size() != 0) chk("rx", 32'({rx_err, rx_data}), 32'(rx_q.pop_front()));
                end
            end
            pwr = u_n_WR;
            prd = u_n_RD;
        end
    end

    initial begin
        int at;
        int n;
        logic pcs;
        n_RST = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        u_DATA_OUT = 8'h00;
        u_Rx_RDY = 1'b0;
        u_Tx_RDY = 1'b0;
        u_PE_Fg = 1'b0;
        u_FE_Fg = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({u_n_RST, u_n_CS, u_n_RD, u_n_WR, u_C_nD, tx_ready, rx_valid, init_done}), 32'h70);
        chk("rst_data", 32'({u_DATA_IN, rx_data, rx_err}), 32'd0);
        do_init();

        // transmit A5; data changes right after the handshake
        @(negedge clk);
        u_Tx_RDY = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        push_w(1'b0, 8'hA5);
        #1 chk("tx_ready_on", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_data = 8'h5A;
        #1 chk("tx_ready_pulse", 32'(tx_ready), 32'd0);
        chk("wr_setup", 32'(u_n_WR), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("wr_fall_at_2", 32'(u_n_WR), 32'd0);
        repeat (8) @(negedge clk);
        chk("tx_done", 32'(acc_q.size()), 32'd0);

        // clean receive of 3C
        u_Rx_RDY = 1'b1;
        u_DATA_OUT = 8'h3C;
        push_r();
        rx_q.push_back({2'b00, 8'h3C});
        at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) u_Rx_RDY = 1'b0;
            if (rx_valid && at == 0) at = k;
        end
        chk("rx_latency", 32'(at), 32'd4);
        chk("rx_done", 32'(rx_q.size()), 32'd0);

        // parity error, then framing error
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            u_Rx_RDY = 1'b1;
            u_PE_Fg = (e == 0);
            u_FE_Fg = (e == 1);
            u_DATA_OUT = (e == 0) ? 8'h3C : 8'h81;
            push_r();
            rx_q.push_back((e == 0) ? {2'b01, 8'h3C} : {2'b10, 8'h81});
`ifdef UART_CTRL_ERRCLR_EN
            push_w(1'b1, 8'h15);
`endif
            @(negedge clk);
            u_Rx_RDY = 1'b0;
            repeat (5) @(negedge clk);
            u_PE_Fg = 1'b0;
            u_FE_Fg = 1'b0;
            repeat (12) @(negedge clk);
            chk("err_acc_left", 32'(acc_q.size()), 32'd0);
            chk("err_rx_left", 32'(rx_q.size()), 32'd0);
        end

        // reset while a write strobe is low
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h96;
        push_w(1'b0, 8'h96);
        @(negedge clk);
        tx_valid = 1'b0;
        at = 0;
        for (int k = 0; k < 10 && at == 0; k++) begin
            @(negedge clk);
            if (!u_n_WR) at = 1;
        end
        chk("wr_seen", 32'(at), 32'd1);
        #2 n_RST = 1'b0;
        #1 chk("midrst_strobes", 32'({u_n_WR, u_n_RD, u_n_CS}), 32'h7);
        chk("midrst_init", 32'({init_done, u_n_RST}), 32'd0);
        repeat (3) @(negedge clk);
        do_init();

        // both sides requesting continuously: RX, TX, RX, TX
        @(negedge clk);
        u_Rx_RDY = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        u_DATA_OUT = 8'h77;
        for (int i = 0; i < 2; i++) begin
            push_r();
            push_w(1'b0, 8'hC3);
            rx_q.push_back({2'b00, 8'h77});
        end
        n = 0;
        pcs = 1'b1;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (pcs && !u_n_CS) n++;
            pcs = u_n_CS;
        end
        u_Rx_RDY = 1'b0;
        tx_valid = 1'b0;
        chk("rr_grants", 32'(n), 32'd4);
        repeat (15) @(negedge clk);
        chk("rr_acc_left", 32'(acc_q.size()), 32'd0);
        chk("rr_rx_left", 32'(rx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_bus_ctrl.md
# uart_bus_ctrl

Host-side controller that sequences the 8251-style `UART` core's parallel bus (`C_nD`, `n_RD`, `n_WR`, `n_CS`, `DATA_IN`, `DATA_OUT`). It resets and initialises the UART with mode and command words, then arbitrates between transmit requests and received-byte reads. It presents a simple valid/ready byte stream to the rest of the design, replacing manual push-button strobing in the board wrapper.

## Interface
Parameters:
- `MODE_WORD`, 8'h4E, mode word written first after UART reset (C_nD=1).
- `CMD_WORD`, 8'h15, command word written second (TxEN, RxE, ER).
- `STROBE_CYCLES`, 2, clk cycles `u_n_RD`/`u_n_WR` are held low per access (>=1).
- `RST_CYCLES`, 8, clk cycles `u_n_RST` is held low at start-up (>=1).

Ports:
- `clk` in 1, system clock (50 MHz domain).
- `n_RST` in 1, asynchronous active-low reset.
- `tx_valid` in 1, byte to transmit is available.
- `tx_data` in 8, byte to transmit.
- `tx_ready` out 1, controller accepts `tx_data` this cycle.
- `rx_valid` out 1, one-cycle pulse: `rx_data` is valid.
- `rx_data` out 8, received byte.
- `rx_err` out 2, {FE, PE} sampled with the byte, valid with `rx_valid`.
- `init_done` out 1, high once both init writes complete.
- `u_n_RST` out 1, UART reset.
- `u_n_CS`, `u_C_nD`, `u_n_RD`, `u_n_WR` out 1 each, UART bus controls.
- `u_DATA_IN` out 8, write data to UART.
- `u_DATA_OUT` in 8, read data from UART.
- `u_Rx_RDY`, `u_Tx_RDY`, `u_PE_Fg`, `u_FE_Fg` in 1 each, UART status.

## Operation
- States: `S_URST` → `S_MODE` → `S_CMD` → `S_IDLE` ↔ {`S_TX`, `S_RX`, `S_ERRCLR`} → `S_RECOV` → `S_IDLE`.
- `S_URST`: `u_n_RST`=0 for `RST_CYCLES`, then 1.
- `S_MODE`/`S_CMD`: bus writes with `u_C_nD`=1 of `MODE_WORD` then `CMD_WORD`. `init_done` rises on the first cycle of `S_IDLE`.
- Bus access: 1 setup cycle (`u_n_CS`=0, `u_C_nD`, `u_DATA_IN` stable), `STROBE_CYCLES` strobe-low, 1 hold cycle (strobe high, CS still low). Total `STROBE_CYCLES`+2 cycles.
- `S_IDLE` request sources: RX = `u_Rx_RDY`; TX = `tx_valid & u_Tx_RDY`.
- Both requests present: round-robin on a `last_grant` bit (reset = TX, so RX wins first). Single request is granted directly.
- `tx_ready` = 1 only in `S_IDLE` when TX is granted that cycle. `tx_data` is latched on the `tx_valid & tx_ready` handshake. `tx_data` is not sampled afterwards.
- `S_TX`: data write (`u_C_nD`=0) of the latched byte.
- `S_RX`: data read (`u_C_nD`=0).
  - `u_DATA_OUT`, PE and FE are captured on the last strobe-low cycle.
  - `rx_valid` pulses in the hold cycle. There is no backpressure.
- `S_RECOV`: 2 cycles with the bus idle so UART flags settle before re-arbitration.
- Reset mid-access: all strobes return high immediately (async) and the sequence restarts at `S_URST`.

## Timing
- Reset values: `u_n_RST`=0, `u_n_CS`=1, `u_n_RD`=1, `u_n_WR`=1, `u_C_nD`=0, `u_DATA_IN`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `rx_err`=0, `init_done`=0.
- Reset deassert → `init_done` at `RST_CYCLES` + 2·(`STROBE_CYCLES`+2 + 2) + 1 cycles (21 with defaults).
- TX handshake → `u_n_WR` falls 2 cycles later (state entry + setup).
- `u_Rx_RDY` seen in IDLE → `rx_valid` after `STROBE_CYCLES`+2 cycles (4 with defaults).
- Back-to-back transfers: minimum `STROBE_CYCLES`+5 cycles apart (IDLE + access + recovery).

## Configuration
- `UART_CTRL_ERRCLR_EN` defined:
  - When a captured PE or FE is 1, `S_RX` proceeds to `S_ERRCLR` instead of `S_RECOV`.
  - `S_ERRCLR` writes `CMD_WORD | 8'h10` with `u_C_nD`=1, then goes to `S_RECOV`.
- Undefined: `S_ERRCLR` is absent. Flags are only reported on `rx_err` and stay latched in the UART.

## Structure
- Package `uart_ctrl_pkg`:
  - state enum `uart_ctrl_state_t`;
  - constants `CMD_ER_BIT` (8'h10) and `RECOV_CYCLES` (2).
- Sub-module `uart_bus_access`: a single-access sequencer.
  - Inputs: `start`, `rnw`, `c_nd`, `wdata`.
  - Outputs: `busy`, `done`, `rdata`, and the CS/RD/WR/C_nD pins.
  - The top FSM issues all accesses through it.

## Test plan
- Reset release → `u_n_RST` low 8 cycles; writes 8'h4E then 8'h15, both with `u_C_nD`=1; `init_done`=1 at cycle 21.
- `tx_valid`=1, `tx_data`=8'hA5, `u_Tx_RDY`=1 → one-cycle `tx_ready`; `u_n_WR` low 2 cycles with `u_DATA_IN`=8'hA5, `u_C_nD`=0.
- `u_Rx_RDY`=1, `u_DATA_OUT`=8'h3C → `u_n_RD` low 2 cycles; `rx_valid` pulse with `rx_data`=8'h3C, `rx_err`=2'b00.
- RX and TX both requesting continuously → grants alternate RX, TX, RX, TX; neither side is starved.
- With `UART_CTRL_ERRCLR_EN`, read with `u_PE_Fg`=1 → `rx_err`=2'b01, then a command write of 8'h15 (which already has ER set) with `u_C_nD`=1; without the macro, no extra write occurs.
- `n_RST` asserted while `u_n_WR`=0 → strobe high immediately, `init_done`=0, init sequence repeats.
